// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and step constants for the RTC bus scheduler
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Step indices within one bus transaction (counter value 0..27).
    localparam logic [4:0] ADDR_LAST = 5'd8;
    localparam logic [4:0] CS_ON_A   = 5'd1;
    localparam logic [4:0] CS_OFF_A  = 5'd7;
    localparam logic [4:0] WR_ON_A   = 5'd2;
    localparam logic [4:0] WR_OFF_A  = 5'd6;
    localparam logic [4:0] CS_ON_D   = 5'd10;
    localparam logic [4:0] CS_OFF_D  = 5'd25;
    localparam logic [4:0] STB_ON_D  = 5'd11;
    localparam logic [4:0] STB_OFF_D = 5'd24;
    localparam logic [4:0] CAP_STEP  = 5'd24;
    localparam logic [4:0] DATA_LAST = 5'd26;
    localparam logic [4:0] STEP_LAST = 5'd27;

endpackage

// File: rtl/rtc_step_counter.sv
// rtl/rtc_step_counter.sv - 5-bit transaction step counter, wraps after LAST
// Ports: clk, clear (synchronous, active-high), en (advance one step), step (current value).
module rtc_step_counter #(
    parameter logic [4:0] LAST = 5'd27
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    output logic [4:0] step
);

    always_ff @(posedge clk) begin
        if (clear) begin
            step <= 5'd0;
        end else if (en) begin
            step <= (step == LAST) ? 5'd0 : step + 5'd1;
        end
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// rtl/rtc_bus_scheduler.sv - arbitrates and sequences the multiplexed RTC bus
// Ports: clk, reset_clk (sync active-high); reader rd_req/rd_addr/rd_gnt/rd_data/rd_valid;
// writer wr_req/wr_addr/wr_data/wr_gnt/wr_done; busy; registered RTC pins bus_cs_n,
// bus_rd_n, bus_wr_n, bus_ad_sel, bus_ad_o, bus_ad_oe; bus_ad_i read back from the pads.
// Optional macro RTC_SCHED_RR_EN: round-robin arbitration instead of fixed writer priority.
module rtc_bus_scheduler #(
    parameter int STEP_LAST = 27,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset_clk,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              busy,
    output logic              bus_cs_n,
    output logic              bus_rd_n,
    output logic              bus_wr_n,
    output logic              bus_ad_sel,
    output logic [DATA_W-1:0] bus_ad_o,
    output logic              bus_ad_oe,
    input  logic [DATA_W-1:0] bus_ad_i
);
    import rtc_pkg::*;

    state_t            state, state_n;
    op_t               op;
    logic [4:0]        step, nxt_step;
    logic [ADDR_W-1:0] addr_q, nxt_addr;
    logic [DATA_W-1:0] data_q, nxt_data;
    logic              grant, pick_wr, nxt_active, nxt_wr;
    logic              p_cs_n, p_rd_n, p_wr_n, p_sel, p_oe;
    logic [DATA_W-1:0] p_ad_o;

    rtc_step_counter #(.LAST(5'(STEP_LAST))) u_step (
        .clk   (clk),
        .clear (reset_clk),
        .en    (state != IDLE),
        .step  (step)
    );

`ifdef RTC_SCHED_RR_EN
    // prio_wr: the writer wins a tie; flips to the other side on every grant.
    logic prio_wr;
    assign pick_wr = wr_req && (!rd_req || prio_wr);

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            prio_wr <= 1'b1;
        end else if (grant) begin
            prio_wr <= !pick_wr;
        end
    end
`else
    assign pick_wr = wr_req;
`endif

    assign grant    = (state == IDLE) && !reset_clk && (rd_req || wr_req);
    assign wr_gnt   = grant && pick_wr;
    assign rd_gnt   = grant && !pick_wr;
    assign busy     = (state != IDLE);
    assign rd_valid = (state == DONE) && (op == OP_RD);
    assign wr_done  = (state == DONE) && (op == OP_WR);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant) state_n = ADDR;
            ADDR:    if (step == ADDR_LAST) state_n = DATA;
            DATA:    if (step == DATA_LAST) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Pins are registered, so the pattern is decoded for the step the next cycle shows.
    always_comb begin
        nxt_step   = (state == IDLE) ? 5'd0 : step + 5'd1;
        nxt_active = (state_n != IDLE);
        nxt_wr     = grant ? pick_wr : (op == OP_WR);
        nxt_addr   = grant ? (pick_wr ? wr_addr : rd_addr) : addr_q;
        nxt_data   = grant ? wr_data : data_q;
        p_cs_n     = 1'b1;
        p_rd_n     = 1'b1;
        p_wr_n     = 1'b1;
        p_sel      = 1'b0;
        p_oe       = 1'b0;
        p_ad_o     = '0;
        if (nxt_active) begin
            if (nxt_step <= ADDR_LAST) begin
                p_sel  = 1'b1;
                p_oe   = 1'b1;
                p_ad_o = nxt_addr;
                p_cs_n = !(nxt_step >= CS_ON_A && nxt_step <= CS_OFF_A);
                p_wr_n = !(nxt_step >= WR_ON_A && nxt_step <= WR_OFF_A);
            end else if (nxt_step <= DATA_LAST) begin
                p_cs_n = !(nxt_step >= CS_ON_D && nxt_step <= CS_OFF_D);
                if (nxt_wr) begin
                    p_oe   = 1'b1;
                    p_ad_o = nxt_data;
                    p_wr_n = !(nxt_step >= STB_ON_D && nxt_step <= STB_OFF_D);
                end else begin
                    p_rd_n = !(nxt_step >= STB_ON_D && nxt_step <= STB_OFF_D);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state      <= IDLE;
            op         <= OP_RD;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data    <= '0;
            bus_cs_n   <= 1'b1;
            bus_rd_n   <= 1'b1;
            bus_wr_n   <= 1'b1;
            bus_ad_sel <= 1'b0;
            bus_ad_oe  <= 1'b0;
            bus_ad_o   <= '0;
        end else begin
            state      <= state_n;
            addr_q     <= nxt_addr;
            data_q     <= nxt_data;
            bus_cs_n   <= p_cs_n;
            bus_rd_n   <= p_rd_n;
            bus_wr_n   <= p_wr_n;
            bus_ad_sel <= p_sel;
            bus_ad_oe  <= p_oe;
            bus_ad_o   <= p_ad_o;
            if (grant) begin
                op <= pick_wr ? OP_WR : OP_RD;
            end
            if (state == DATA && op == OP_RD && step == CAP_STEP) begin
                rd_data <= bus_ad_i;
            end
        end
    end

endmodule
